// File: rtl/fetch_queue.sv
// fetch_queue: multi-lane circular instruction buffer between fetch and decode.
// Pushes the contiguous lane-0 run of valid inputs and pops the contiguous run of accepted outputs.
module fetch_queue #(
   parameter int XLEN      = 32,
   parameter int ILEN      = 32,
   parameter int DEPTH     = 8,
   parameter int IN_LANES  = 2,
   parameter int OUT_LANES = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic [IN_LANES-1:0]          in_valid,
   input  logic [IN_LANES*ILEN-1:0]     in_instr,
   input  logic [IN_LANES*XLEN-1:0]     in_pc,
   output logic                         in_ready,
   output logic [OUT_LANES-1:0]         out_valid,
   output logic [OUT_LANES*ILEN-1:0]    out_instr,
   output logic [OUT_LANES*XLEN-1:0]    out_pc,
   input  logic [OUT_LANES-1:0]         out_ready,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int EW = XLEN + ILEN;
   localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
   localparam logic [CW-1:0] IN_LANES_C = CW'(IN_LANES);

   logic [EW-1:0]        mem_q [DEPTH];
   logic [AW-1:0]        head_q, head_d;
   logic [AW-1:0]        tail_q, tail_d;
   logic [CW-1:0]        count_q, count_d;
   logic [CW-1:0]        push_cnt, pop_cnt;
   logic [IN_LANES-1:0]  push_lane;

   // Space check uses the registered count only, so decode back-pressure never reaches fetch combinationally.
   assign in_ready = ((DEPTH_C - count_q) >= IN_LANES_C) && !flush;
   assign count    = count_q;

   generate
      for (genvar gi = 0; gi < OUT_LANES; gi++) begin : g_out
         assign out_valid[gi] = (count_q > CW'(gi)) && !flush;
         assign {out_pc[gi*XLEN +: XLEN], out_instr[gi*ILEN +: ILEN]} = mem_q[head_q + AW'(gi)];
      end
   endgenerate

   always_comb begin
      logic run;
      run       = in_ready;
      push_lane = '0;
      push_cnt  = '0;
      for (int k = 0; k < IN_LANES; k++) begin
         run          = run & in_valid[k];
         push_lane[k] = run;
         push_cnt     = push_cnt + CW'(run);
      end
   end

   always_comb begin
      logic run;
      run     = 1'b1;
      pop_cnt = '0;
      for (int k = 0; k < OUT_LANES; k++) begin
         run     = run & out_valid[k] & out_ready[k];
         pop_cnt = pop_cnt + CW'(run);
      end
   end

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         head_d  = head_q + AW'(pop_cnt);
         tail_d  = tail_q + AW'(push_cnt);
         count_d = count_q + push_cnt - pop_cnt;
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < IN_LANES; k++) begin
         if (push_lane[k]) begin
            mem_q[tail_q + AW'(k)] <= {in_pc[k*XLEN +: XLEN], in_instr[k*ILEN +: ILEN]};
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (reset) begin
         assert (count_q <= DEPTH_C);
      end
   end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, dual/partial lanes, fill/wrap, random traffic vs a queue model, flush.
module tb_fetch_queue;
   localparam int XLEN = 32, ILEN = 32, DEPTH = 8, IL = 2, OL = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        flush = 1'b0;
   logic [1:0]  in_valid = '0;
   logic [1:0]  out_ready = '0;
   logic [63:0] in_instr = '0;
   logic [63:0] in_pc = '0;
   logic        in_ready;
   logic [1:0]  out_valid;
   logic [63:0] out_instr;
   logic [63:0] out_pc;
   logic [3:0]  count;

   int          total = 0;
   int          bad = 0;
   logic [31:0] mq_pc[$];
   logic [31:0] next_pc;

   always #5 clk = ~clk;

   fetch_queue #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .IN_LANES(IL), .OUT_LANES(OL)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_ready(in_ready),
      .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .out_ready(out_ready),
      .count(count)
   );

   function automatic logic [31:0] instr_of(input logic [31:0] pc);
      return pc ^ 32'hA5A5_0000;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [1:0] iv, input logic [31:0] pc0, input logic [31:0] pc1,
                        input logic [1:0] ordy);
      in_valid  = iv;
      in_pc     = {pc1, pc0};
      in_instr  = {instr_of(pc1), instr_of(pc0)};
      out_ready = ordy;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // One cycle of traffic checked against the queue model.
   task automatic mstep(input logic [1:0] iv, input logic [1:0] ordy);
      int p, q;
      logic exp_rdy;
      logic [1:0] exp_ov;
      drive(iv, next_pc, next_pc + 32'd4, ordy);
      #1;
      exp_rdy = (DEPTH - mq_pc.size()) >= IL;
      exp_ov  = {mq_pc.size() > 1, mq_pc.size() > 0};
      chk("m_in_ready", 64'(in_ready), 64'(exp_rdy));
      chk("m_out_valid", 64'(out_valid), 64'(exp_ov));
      if (exp_ov[0]) begin
         chk("m_pc0", 64'(out_pc[31:0]), 64'(mq_pc[0]));
         chk("m_instr0", 64'(out_instr[31:0]), 64'(instr_of(mq_pc[0])));
      end
      if (exp_ov[1]) begin
         chk("m_pc1", 64'(out_pc[63:32]), 64'(mq_pc[1]));
      end
      p = !exp_rdy ? 0 : (iv[0] ? (iv[1] ? 2 : 1) : 0);
      q = (exp_ov[0] & ordy[0]) ? ((exp_ov[1] & ordy[1]) ? 2 : 1) : 0;
      tick;
      for (int i = 0; i < q; i++) void'(mq_pc.pop_front());
      if (p >= 1) mq_pc.push_back(next_pc);
      if (p == 2) mq_pc.push_back(next_pc + 32'd4);
      next_pc = next_pc + 32'(4 * p);
      chk("m_count", 64'(count), 64'(mq_pc.size()));
   endtask

   initial begin
      // 1: reset and idle
      #3;
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      #9;
      reset = 1'b1;
      tick;
      drive(2'b00, 0, 0, 2'b11);
      #1;
      chk("idle_out_valid", 64'(out_valid), 64'd0);
      tick;
      chk("idle_no_pop", 64'(count), 64'd0);

      // 2: dual push then dual pop
      drive(2'b11, 32'h0, 32'h4, 2'b00);
      #1;
      chk("dual_in_ready", 64'(in_ready), 64'd1);
      chk("dual_no_bypass", 64'(out_valid), 64'd0);
      tick;
      drive(2'b00, 0, 0, 2'b11);
      #1;
      chk("dual_count2", 64'(count), 64'd2);
      chk("dual_out_valid", 64'(out_valid), 64'd3);
      chk("dual_pc0", 64'(out_pc[31:0]), 64'h0);
      chk("dual_pc1", 64'(out_pc[63:32]), 64'h4);
      chk("dual_instr1", 64'(out_instr[63:32]), 64'(instr_of(32'h4)));
      tick;
      chk("dual_count0", 64'(count), 64'd0);

      // 3: partial lanes
      drive(2'b10, 32'h40, 32'h44, 2'b00);
      tick;
      chk("gap_push_none", 64'(count), 64'd0);
      drive(2'b01, 32'h48, 32'h4c, 2'b00);
      tick;
      drive(2'b00, 0, 0, 2'b10);
      #1;
      chk("lane0_push_count", 64'(count), 64'd1);
      chk("lane0_out_valid", 64'(out_valid), 64'd1);
      chk("lane0_pc", 64'(out_pc[31:0]), 64'h48);
      tick;
      chk("gap_pop_none", 64'(count), 64'd1);
      drive(2'b00, 0, 0, 2'b01);
      tick;
      chk("lane0_pop", 64'(count), 64'd0);
      flush = 1'b1;
      drive(2'b00, 0, 0, 2'b00);
      tick;
      flush = 1'b0;
      chk("preflush_count", 64'(count), 64'd0);

      // 4: fill, drain two, wrap
      for (int i = 0; i < 4; i++) begin
         drive(2'b11, 32'(8 * i), 32'(8 * i + 4), 2'b00);
         tick;
      end
      drive(2'b00, 0, 0, 2'b00);
      #1;
      chk("full_count", 64'(count), 64'd8);
      chk("full_in_ready", 64'(in_ready), 64'd0);
      drive(2'b01, 32'h80, 32'h84, 2'b00);
      tick;
      chk("full_lane0_held", 64'(count), 64'd8);
      drive(2'b00, 0, 0, 2'b01);
      #1;
      chk("full_head_pc", 64'(out_pc[31:0]), 64'h0);
      tick;
      chk("pop1_count", 64'(count), 64'd7);
      chk("pop1_in_ready", 64'(in_ready), 64'd0);
      #1;
      chk("pop1_head_pc", 64'(out_pc[31:0]), 64'h4);
      tick;
      chk("pop2_count", 64'(count), 64'd6);
      chk("pop2_in_ready", 64'(in_ready), 64'd1);
      drive(2'b11, 32'h20, 32'h24, 2'b00);
      tick;
      drive(2'b00, 0, 0, 2'b11);
      #1;
      chk("wrap_count", 64'(count), 64'd8);
      for (int j = 0; j < 4; j++) begin
         chk("wrap_valid", 64'(out_valid), 64'd3);
         chk("wrap_pc0", 64'(out_pc[31:0]), 64'(32'h8 + 32'(8 * j)));
         chk("wrap_pc1", 64'(out_pc[63:32]), 64'(32'hc + 32'(8 * j)));
         tick;
         #1;
      end
      chk("wrap_drained", 64'(count), 64'd0);

      // 5: concurrent push/pop against the queue model
      next_pc = 32'h200;
      mstep(2'b11, 2'b00);
      mstep(2'b11, 2'b00);
      mstep(2'b11, 2'b00);
      mstep(2'b11, 2'b11);
      for (int i = 0; i < 64; i++) begin
         mstep(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      end

      // 6: flush with traffic pending
      flush = 1'b1;
      drive(2'b00, 0, 0, 2'b00);
      tick;
      flush = 1'b0;
      chk("flush_pre", 64'(count), 64'd0);
      drive(2'b11, 32'h300, 32'h304, 2'b00);
      tick;
      tick;
      drive(2'b01, 32'h308, 32'h30c, 2'b00);
      tick;
      drive(2'b00, 0, 0, 2'b00);
      #1;
      chk("flush_count5", 64'(count), 64'd5);
      flush = 1'b1;
      drive(2'b11, 32'h400, 32'h404, 2'b11);
      #1;
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      chk("flush_in_ready", 64'(in_ready), 64'd0);
      tick;
      flush = 1'b0;
      drive(2'b00, 0, 0, 2'b00);
      #1;
      chk("flush_count0", 64'(count), 64'd0);
      chk("flush_empty", 64'(out_valid), 64'd0);
      drive(2'b01, 32'h100, 32'h104, 2'b00);
      tick;
      drive(2'b00, 0, 0, 2'b00);
      #1;
      chk("post_flush_valid", 64'(out_valid), 64'd1);
      chk("post_flush_pc", 64'(out_pc[31:0]), 64'h100);
      chk("post_flush_count", 64'(count), 64'd1);

      // asynchronous reset mid-operation, no clock edge
      #2;
      reset = 1'b0;
      #1;
      chk("async_rst_count", 64'(count), 64'd0);
      chk("async_rst_valid", 64'(out_valid), 64'd0);
      chk("async_rst_ready", 64'(in_ready), 64'd1);
      reset = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
